coherence_bus_ctrl: RTL and testbench

- Shared bus/coherence controller that sits directly downstream of the two per-core dcaches and icaches.
- Arbitrates their RAM requests and serves dcache read misses, snooping the other core's dcache first so dirty data moves cache-to-cache.
- Broadcasts write-invalidates to the other core.
- Owns the single-port RAM interface.

---
 rtl/coherence_bus_ctrl_if.sv | 44 ++++
 rtl/coherence_bus_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coherence_bus_ctrl_if.sv
// Bundle of the cache-side and RAM-side signals of the coherence bus controller.
// The slave modport is the controller's view.
// The master modport is the view of the caches plus the RAM that surround it.
interface coherence_bus_ctrl_if #(
   parameter int CPUS = 2
);
   // instruction side
   logic [CPUS-1:0]        iREN;
   logic [CPUS-1:0][31:0]  iaddr;
   logic [CPUS-1:0]        iwait;
   logic [CPUS-1:0][31:0]  iload;
   // data side
   logic [CPUS-1:0]        dREN;
   logic [CPUS-1:0]        dWEN;
   logic [CPUS-1:0][31:0]  daddr;
   logic [CPUS-1:0][31:0]  dstore;
   logic [CPUS-1:0]        dwait;
   logic [CPUS-1:0][31:0]  dload;
   // coherence side
   logic [CPUS-1:0]        ccwrite;
   logic [CPUS-1:0]        cctrans;
   logic [CPUS-1:0]        ccwait;
   logic [CPUS-1:0]        ccinv;
   logic [CPUS-1:0][31:0]  ccsnoopaddr;
   // single-port RAM
   logic                   ramREN;
   logic                   ramWEN;
   logic [31:0]            ramaddr;
   logic [31:0]            ramstore;
   logic [31:0]            ramload;
   logic [1:0]             ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
      output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
             ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
      input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
             ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-core bus and coherence controller.
// It arbitrates dcache and icache RAM traffic, and snoops the other dcache on read misses.
// It broadcasts write-invalidates and owns the single RAM port.
module coherence_bus_ctrl #(
   parameter int CPUS      = 2,
   parameter int BURST_MAX = 4
) (
   input  logic                 CLK,
   input  logic                 nRST,
   coherence_bus_ctrl_if.slave  bus
);

   localparam int              BW        = $clog2(BURST_MAX + 1);
   localparam logic [BW-1:0]   BURST_LIM = BW'(BURST_MAX);

   typedef enum logic [3:0] {
      IDLE, SNOOP_SETUP, SNOOP_RESP, C2C, RAM_RD, RAM_WR, INV_SETUP, INV, IFETCH
   } state_t;

   typedef enum logic [1:0] {
      RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR
   } ram_state_t;

   state_t               state, state_nx;
   logic                 grant, grant_nx;
   logic                 rr, rr_nx;
   logic [BW-1:0]        burst, burst_nx;
   logic                 dg;
   logic                 o_core;
   logic                 active;
   logic                 access;
   logic [CPUS-1:0]      dreq;

   logic [CPUS-1:0]        iwait_c, dwait_c, ccwait_c, ccinv_c;
   logic [CPUS-1:0][31:0]  iload_c, dload_c, snoop_c;
   logic                   ren_c, wen_c;
   logic [31:0]            raddr_c, rstore_c;

   assign dreq   = bus.dREN | bus.dWEN | bus.ccwrite;
   assign o_core = ~grant;
   assign access = (ram_state_t'(bus.ramstate) == RAM_ACCESS);

   // Transaction state, granted core, round-robin pointer and burst length.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         grant <= 1'b0;
         rr    <= 1'b0;
         burst <= '0;
      end else begin
         // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
         state <= state_nx;
         grant <= grant_nx;
         rr    <= rr_nx;
         burst <= burst_nx;
      end
   end

   // Whether the granted core still holds the request that opened the current transaction.
   always_comb begin
      active = 1'b0;
      case (state)
         SNOOP_SETUP, SNOOP_RESP, C2C, RAM_RD: active = bus.dREN[grant];
         RAM_WR:                               active = bus.dWEN[grant];
         INV_SETUP, INV:                       active = bus.ccwrite[grant];
         IFETCH:                               active = bus.iREN[grant];
         default:                              active = 1'b0;
      endcase
   end

   // Arbitration, dispatch, next state and all bus outputs.
   always_comb begin
      // NOTE: every combinational signal gets a default first so no path infers a latch.
      state_nx = state;
      grant_nx = grant;
      rr_nx    = rr;
      burst_nx = burst;
      dg       = grant;
      iwait_c  = '1;
      dwait_c  = '1;
      iload_c  = '0;
      dload_c  = '0;
      ccwait_c = '0;
      ccinv_c  = '0;
      snoop_c  = '0;
      ren_c    = 1'b0;
      wen_c    = 1'b0;
      raddr_c  = '0;
      rstore_c = '0;

      if (state == IDLE) begin
         if (|dreq) begin
            // Keep the current core until its burst is spent, then fall back to round-robin.
            if (dreq[grant] && (burst < BURST_LIM)) begin
               dg       = grant;
               burst_nx = burst + BW'(1);
            end else begin
               dg       = dreq[rr] ? rr : ~rr;
               burst_nx = BW'(1);
            end
            grant_nx = dg;
            if ((dg != grant) || (burst_nx == BURST_LIM))
               rr_nx = ~dg;
            if (bus.dWEN[dg])
               state_nx = RAM_WR;
            else if (bus.ccwrite[dg])
               state_nx = INV_SETUP;
            else
               state_nx = SNOOP_SETUP;
         end else if (|bus.iREN) begin
            grant_nx = bus.iREN[0] ? 1'b0 : 1'b1;
            burst_nx = '0;
            state_nx = IFETCH;
         end
      end else if (!active) begin
         // The requester gave up: abandon quietly, without a completion strobe.
         state_nx = IDLE;
      end else begin
         case (state)
            SNOOP_SETUP, SNOOP_RESP: begin
               ccwait_c[o_core] = 1'b1;
               snoop_c[o_core]  = bus.daddr[grant];
               if (state == SNOOP_SETUP)
                  state_nx = SNOOP_RESP;
               else
                  state_nx = bus.cctrans[o_core] ? C2C : RAM_RD;
            end
            C2C: begin
               // Dirty block flows to the requester and is written back in the same access.
               ccwait_c[o_core] = 1'b1;
               snoop_c[o_core]  = bus.daddr[grant];
               wen_c            = 1'b1;
               raddr_c          = bus.daddr[grant];
               rstore_c         = bus.dstore[o_core];
               dload_c[grant]   = bus.dstore[o_core];
               if (access) begin
                  dwait_c[grant] = 1'b0;
                  state_nx       = IDLE;
               end
            end
            RAM_RD: begin
               ren_c   = 1'b1;
               raddr_c = bus.daddr[grant];
               if (access) begin
                  dload_c[grant] = bus.ramload;
                  dwait_c[grant] = 1'b0;
                  state_nx       = IDLE;
               end
            end
            RAM_WR: begin
               wen_c    = 1'b1;
               raddr_c  = bus.daddr[grant];
               rstore_c = bus.dstore[grant];
               if (access) begin
                  dwait_c[grant] = 1'b0;
                  state_nx       = IDLE;
               end
            end
            INV_SETUP: begin
               ccwait_c[o_core] = 1'b1;
               snoop_c[o_core]  = bus.daddr[grant];
               state_nx         = INV;
            end
            INV: begin
               // The invalidate strobe doubles as the requester's acknowledge.
               ccwait_c[o_core] = 1'b1;
               snoop_c[o_core]  = bus.daddr[grant];
               ccinv_c          = '1;
               state_nx         = IDLE;
            end
            IFETCH: begin
               ren_c   = 1'b1;
               raddr_c = bus.iaddr[grant];
               if (access) begin
                  iload_c[grant] = bus.ramload;
                  iwait_c[grant] = 1'b0;
                  state_nx       = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign bus.iwait       = iwait_c;
   assign bus.iload       = iload_c;
   assign bus.dwait       = dwait_c;
   assign bus.dload       = dload_c;
   assign bus.ccwait      = ccwait_c;
   assign bus.ccinv       = ccinv_c;
   assign bus.ccsnoopaddr = snoop_c;
   assign bus.ramREN      = ren_c;
   assign bus.ramWEN      = wen_c;
   assign bus.ramaddr     = raddr_c;
   assign bus.ramstore    = rstore_c;

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl.
// A table of single transactions is followed by hand-written multi-cycle sequences.
module tb_coherence_bus_ctrl;

   logic CLK = 1'b0;
   logic nRST;

   coherence_bus_ctrl_if bus ();

   coherence_bus_ctrl dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
   );

   always #5 CLK = ~CLK;

   // RAM model: BUSY until the access has been held ram_lat cycles, optionally forced.
   int         ram_lat   = 1;
   logic [1:0] ram_force = 2'd0;
   int         ram_cnt;

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Cycles the current RAM access has been waiting.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         ram_cnt <= 0;
      else if ((bus.ramREN || bus.ramWEN) && bus.ramstate != 2'd2)
         ram_cnt <= ram_cnt + 1;
      else
         ram_cnt <= 0;
   end

   // RAM status and read data seen by the controller.
   always_comb begin
      bus.ramstate = 2'd0;
      if (bus.ramREN || bus.ramWEN) begin
         if (ram_force != 2'd0)
            bus.ramstate = ram_force;
         else
            bus.ramstate = (ram_cnt >= ram_lat - 1) ? 2'd2 : 2'd1;
      end
      bus.ramload = ram_word(bus.ramaddr);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.iREN    = '0;
      bus.iaddr   = '0;
      bus.dREN    = '0;
      bus.dWEN    = '0;
      bus.daddr   = '0;
      bus.dstore  = '0;
      bus.ccwrite = '0;
      bus.cctrans = '0;
   endtask

   typedef enum int {K_RD, K_WR, K_INV, K_IF} kind_t;

   typedef struct {
      logic        core;
      kind_t       kind;
      logic [31:0] addr;
      logic [31:0] wdata;    // dstore of the requester
      logic [31:0] odata;    // dstore of the other core (snoop response data)
      logic        dirty;    // cctrans of the other core
      int          lat;
      int          e_cyc;    // completion cycle, request applied in cycle 0
      logic [31:0] e_data;   // dload/iload of the requester at completion
      logic [31:0] e_store;  // ramstore at completion
      int          e_ccw;    // cycles with ccwait on the other core up to completion
      logic [31:0] e_snoop;  // ccsnoopaddr of the other core in cycle 1
      logic        e_ren;
      logic        e_wen;
   } txn_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic [31:0] store;
      int          ccw;
      logic [31:0] snoop;
      logic        ren;
      logic        wen;
   } res_t;

   // Apply one transaction, watch it to completion (bounded), then release the request.
   task automatic run_txn(input txn_t v, output res_t r);
      logic c, o, done;
      c = v.core;
      o = ~v.core;
      r = '{cyc: -1, data: '0, store: '0, ccw: 0, snoop: '0, ren: 1'b0, wen: 1'b0};
      @(posedge CLK); #1;
      ram_lat = v.lat;
      case (v.kind)
         K_RD:  begin bus.dREN[c] = 1'b1; bus.daddr[c] = v.addr; end
         K_WR:  begin bus.dWEN[c] = 1'b1; bus.daddr[c] = v.addr; bus.dstore[c] = v.wdata; end
         K_INV: begin bus.ccwrite[c] = 1'b1; bus.daddr[c] = v.addr; end
         K_IF:  begin bus.iREN[c] = 1'b1; bus.iaddr[c] = v.addr; end
         default: ;
      endcase
      bus.dstore[o]  = v.odata;
      bus.cctrans[o] = v.dirty;
      for (int k = 0; k < 20 && r.cyc < 0; k++) begin
         @(negedge CLK);
         if (bus.ccwait[o]) r.ccw++;
         if (k == 1) r.snoop = bus.ccsnoopaddr[o];
         if (bus.ramREN) r.ren = 1'b1;
         if (bus.ramWEN) r.wen = 1'b1;
         case (v.kind)
            K_INV:   done = bus.ccinv[c];
            K_IF:    done = !bus.iwait[c];
            default: done = !bus.dwait[c];
         endcase
         if (done) begin
            r.cyc   = k;
            r.data  = (v.kind == K_IF) ? bus.iload[c] : bus.dload[c];
            r.store = bus.ramstore;
         end
      end
      @(posedge CLK); #1;
      clear_inputs();
   endtask

   txn_t vec [10];
   res_t res;
   int   order [12];
   int   exp_order [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
   int   got, d_cyc, i_cyc, d_low, i_low, lows, wens;
   logic [31:0] dl, il;
   logic ren4, ren5;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = '{1'b0, K_RD,  32'h100, 32'h0,        32'h0,        1'b0, 2, 4, 32'hDEADBEEF, 32'h0,        2, 32'h100, 1'b1, 1'b0};
      vec[1] = '{1'b0, K_RD,  32'h200, 32'h0,        32'h12345678, 1'b1, 2, 4, 32'h12345678, 32'h12345678, 4, 32'h200, 1'b0, 1'b1};
      vec[2] = '{1'b1, K_INV, 32'h40,  32'h0,        32'h0,        1'b0, 1, 2, 32'h0,        32'h0,        2, 32'h40,  1'b0, 1'b0};
      vec[3] = '{1'b1, K_WR,  32'h80,  32'hCAFEF00D, 32'h0,        1'b0, 2, 2, 32'h0,        32'hCAFEF00D, 0, 32'h0,   1'b0, 1'b1};
      vec[4] = '{1'b1, K_RD,  32'h300, 32'h0,        32'h0,        1'b0, 1, 3, 32'h0300FCFF, 32'h0,        2, 32'h300, 1'b1, 1'b0};
      vec[5] = '{1'b0, K_IF,  32'h1000,32'h0,        32'h0,        1'b0, 2, 2, 32'h1000EFFF, 32'h0,        0, 32'h0,   1'b1, 1'b0};
      vec[6] = '{1'b1, K_IF,  32'h24,  32'h0,        32'h0,        1'b0, 3, 3, 32'h0024FFDB, 32'h0,        0, 32'h0,   1'b1, 1'b0};
      vec[7] = '{1'b1, K_RD,  32'h500, 32'h0,        32'hA5A55A5A, 1'b1, 1, 3, 32'hA5A55A5A, 32'hA5A55A5A, 3, 32'h500, 1'b0, 1'b1};
      vec[8] = '{1'b0, K_WR,  32'h104, 32'h01020304, 32'h0,        1'b0, 1, 1, 32'h0,        32'h01020304, 0, 32'h0,   1'b0, 1'b1};
      vec[9] = '{1'b0, K_INV, 32'h7C,  32'h0,        32'h0,        1'b0, 1, 2, 32'h0,        32'h0,        2, 32'h7C,  1'b0, 1'b0};

      nRST = 1'b0;
      clear_inputs();
      #13;
      check("rst.dwait",   {30'd0, bus.dwait},  32'h3);
      check("rst.iwait",   {30'd0, bus.iwait},  32'h3);
      check("rst.ccwait",  {30'd0, bus.ccwait}, 32'h0);
      check("rst.ccinv",   {30'd0, bus.ccinv},  32'h0);
      check("rst.ramen",   {30'd0, bus.ramREN, bus.ramWEN}, 32'h0);
      check("rst.ramaddr", bus.ramaddr, 32'h0);
      check("rst.ramstore", bus.ramstore, 32'h0);
      check("rst.snoop",   bus.ccsnoopaddr[0] | bus.ccsnoopaddr[1], 32'h0);
      check("rst.dload",   bus.dload[0] | bus.dload[1], 32'h0);
      check("rst.iload",   bus.iload[0] | bus.iload[1], 32'h0);
      @(negedge CLK);
      nRST = 1'b1;

      // Table of single transactions.
      for (int i = 0; i < 10; i++) begin
         run_txn(vec[i], res);
         check($sformatf("v%0d.cycle", i),  res.cyc,   vec[i].e_cyc);
         check($sformatf("v%0d.data", i),   res.data,  vec[i].e_data);
         check($sformatf("v%0d.ramstore", i), res.store, vec[i].e_store);
         check($sformatf("v%0d.ccwait", i), res.ccw,   vec[i].e_ccw);
         check($sformatf("v%0d.snoop", i),  res.snoop, vec[i].e_snoop);
         check($sformatf("v%0d.ramREN", i), {31'd0, res.ren}, {31'd0, vec[i].e_ren});
         check($sformatf("v%0d.ramWEN", i), {31'd0, res.wen}, {31'd0, vec[i].e_wen});
      end

      // Burst fairness: both cores stream reads from reset (rr=0).
      @(posedge CLK); #3 nRST = 1'b0; #3 nRST = 1'b1;
      @(posedge CLK); #1;
      ram_lat = 1;
      for (int k = 0; k < 12; k++) order[k] = -1;
      bus.daddr[0] = 32'h100;
      bus.daddr[1] = 32'h300;
      bus.dREN     = 2'b11;
      got = 0;
      for (int k = 0; k < 200 && got < 12; k++) begin
         @(negedge CLK);
         if (!bus.dwait[0]) begin order[got] = 0; got++; end
         else if (!bus.dwait[1]) begin order[got] = 1; got++; end
      end
      @(posedge CLK); #1;
      clear_inputs();
      check("burst.count", got, 12);
      for (int k = 0; k < 12; k++)
         check($sformatf("burst.grant%0d", k), order[k], exp_order[k]);

      // Data before instruction: iREN[0] and dREN[1] raised together.
      @(posedge CLK); #1;
      ram_lat = 2;
      bus.iaddr[0] = 32'h2000;
      bus.daddr[1] = 32'h300;
      bus.iREN[0]  = 1'b1;
      bus.dREN[1]  = 1'b1;
      d_cyc = -1; i_cyc = -1; d_low = 0; i_low = 0; dl = '0; il = '0;
      for (int k = 0; k < 14; k++) begin
         @(negedge CLK);
         if (!bus.dwait[1]) begin d_cyc = k; d_low++; dl = bus.dload[1]; end
         if (!bus.iwait[0]) begin i_cyc = k; i_low++; il = bus.iload[0]; end
         @(posedge CLK); #1;
         if (d_cyc == k) bus.dREN[1] = 1'b0;
         if (i_cyc == k) bus.iREN[0] = 1'b0;
      end
      clear_inputs();
      check("prio.dcycle", d_cyc, 4);
      check("prio.icycle", i_cyc, 7);
      check("prio.dlow",   d_low, 1);
      check("prio.ilow",   i_low, 1);
      check("prio.dload",  dl, 32'h0300FCFF);
      check("prio.iload",  il, 32'h2000DFFF);

      // Request dropped while RAM is BUSY: no completion, back to idle.
      @(posedge CLK); #1;
      ram_force   = 2'd1;
      bus.daddr[0] = 32'h100;
      bus.dREN[0]  = 1'b1;
      lows = 0; ren4 = 1'b0; ren5 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (bus.dwait != 2'b11) lows++;
         if (k == 4) ren4 = bus.ramREN;
         if (k == 5) ren5 = bus.ramREN;
         @(posedge CLK); #1;
         if (k == 4) bus.dREN[0] = 1'b0;
      end
      ram_force = 2'd0;
      clear_inputs();
      check("drop.ren_before", {31'd0, ren4}, 32'h1);
      check("drop.ren_after",  {31'd0, ren5}, 32'h0);
      check("drop.no_strobe",  lows, 0);

      // ERROR is retried with outputs held until the RAM finally grants access.
      @(posedge CLK); #1;
      ram_lat   = 1;
      ram_force = 2'd3;
      bus.daddr[1]  = 32'h88;
      bus.dstore[1] = 32'h55AA55AA;
      bus.dWEN[1]   = 1'b1;
      d_cyc = -1; lows = 0; wens = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         if (k >= 1 && k <= 5 && bus.ramWEN && bus.ramaddr == 32'h88 && bus.ramstore == 32'h55AA55AA)
            wens++;
         if (!bus.dwait[1]) begin d_cyc = k; lows++; end
         @(posedge CLK); #1;
         if (k == 5) ram_force = 2'd0;
         if (d_cyc == k) clear_inputs();
      end
      clear_inputs();
      check("err.held",  wens, 5);
      check("err.cycle", d_cyc, 6);
      check("err.lows",  lows, 1);

      // Asynchronous reset in the middle of a BUSY RAM read.
      @(posedge CLK); #1;
      ram_force    = 2'd1;
      bus.daddr[0] = 32'h100;
      bus.dREN[0]  = 1'b1;
      ren4 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         if (k == 4) ren4 = bus.ramREN;
      end
      check("rstmid.ren_before", {31'd0, ren4}, 32'h1);
      #2 nRST = 1'b0;
      #1;
      check("rstmid.ramREN", {31'd0, bus.ramREN}, 32'h0);
      check("rstmid.ramaddr", bus.ramaddr, 32'h0);
      check("rstmid.dwait",  {30'd0, bus.dwait},  32'h3);
      check("rstmid.ccwait", {30'd0, bus.ccwait}, 32'h0);
      clear_inputs();
      ram_force = 2'd0;
      lows = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         if (bus.dwait != 2'b11) lows++;
      end
      check("rstmid.no_strobe", lows, 0);
      #2 nRST = 1'b1;
      run_txn(vec[4], res);
      check("rstmid.fresh_cycle", res.cyc,  vec[4].e_cyc);
      check("rstmid.fresh_data",  res.data, vec[4].e_data);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
